// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares the single combinational ROM read port between instruction fetch
//   and the load unit. At most one grant per cycle: load wins unless it has
//   already taken MAX_LD_STREAK consecutive grants while fetch was waiting.
//   Each granted access gets a registered response one cycle later, flagged
//   with rerr for misaligned or out-of-range addresses.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request and byte address (held until granted)
//   if_ready              : fetch granted this cycle (combinational)
//   if_rvalid/rdata/rerr  : registered fetch response
//   ld_*                  : same roles for the load side
//   rom_address           : address to ROM (0 when idle)
//   rom_data              : ROM read data, combinational from rom_address

// Per-requester response register. Side index 0 = fetch, 1 = load.
module rom_port_arbiter_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_gnt,
  input  logic        i_err,
  input  logic [31:0] i_rdata,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_rerr
);
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
      o_rerr   <= 1'b0;
    end else begin
      o_rvalid <= i_gnt;
      // data/err hold while no response is issued
      if (i_gnt) begin
        o_rdata <= i_err ? '0 : i_rdata;
        o_rerr  <= i_err;
      end
    end
  end
endmodule

module rom_port_arbiter #(
  parameter int ROM_BYTES     = 4096,
  parameter int MAX_LD_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_rerr,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_ready,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic        ld_rerr,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data
);
  localparam int          NUM_SIDES    = 2;
  localparam logic [3:0]  LP_MAX       = 4'(MAX_LD_STREAK);
  localparam logic [31:0] LP_ROM_BYTES = 32'(ROM_BYTES);

  logic [3:0]                  r_streak;
  logic                        w_if_gnt;
  logic                        w_ld_gnt;
  logic [31:0]                 w_addr;
  logic                        w_err;
  logic [NUM_SIDES-1:0]        w_gnt;
  logic [NUM_SIDES-1:0]        w_rvalid;
  logic [NUM_SIDES-1:0]        w_rerr;
  logic [NUM_SIDES-1:0][31:0]  w_rdata;

  // Load has priority until it has taken LP_MAX grants in a row against a
  // waiting fetch; the threshold uses the pre-edge streak value.
  always_comb begin
    w_ld_gnt = !reset && ld_req && (!if_req || (r_streak < LP_MAX));
    w_if_gnt = !reset && if_req && !w_ld_gnt;
  end

  always_comb begin
    w_addr = '0;
    if (w_ld_gnt)      w_addr = ld_addr;
    else if (w_if_gnt) w_addr = if_addr;
  end

  // One check on the muxed address serves both sides: only one is granted.
  assign w_err       = (w_addr[1:0] != 2'b00) || (w_addr >= LP_ROM_BYTES);
  assign rom_address = w_addr;
  assign if_ready    = w_if_gnt;
  assign ld_ready    = w_ld_gnt;
  assign w_gnt       = {w_ld_gnt, w_if_gnt};

  // Streak counts load wins only while fetch is actually waiting.
  always_ff @(posedge clk) begin
    if (reset)
      r_streak <= '0;
    else if (!if_req || w_if_gnt)
      r_streak <= '0;
    else if (w_ld_gnt && (r_streak < LP_MAX))
      r_streak <= r_streak + 4'd1;
  end

  for (genvar g = 0; g < NUM_SIDES; g++) begin : g_resp
    rom_port_arbiter_resp u_resp (
      .clk      (clk),
      .reset    (reset),
      .i_gnt    (w_gnt[g]),
      .i_err    (w_err),
      .i_rdata  (rom_data),
      .o_rvalid (w_rvalid[g]),
      .o_rdata  (w_rdata[g]),
      .o_rerr   (w_rerr[g])
    );
  end

  assign if_rvalid = w_rvalid[0];
  assign if_rdata  = w_rdata[0];
  assign if_rerr   = w_rerr[0];
  assign ld_rvalid = w_rvalid[1];
  assign ld_rdata  = w_rdata[1];
  assign ld_rerr   = w_rerr[1];
endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;
  localparam int ROM_BYTES = 4096;
  localparam int MAX_LD    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ld_req;
  logic [31:0] if_addr, ld_addr;
  logic        if_ready, ld_ready;
  logic        if_rvalid, ld_rvalid, if_rerr, ld_rerr;
  logic [31:0] if_rdata, ld_rdata;
  logic [31:0] rom_address, rom_data;

  logic [31:0] rom [1024];

  int vectors = 0;
  int errs    = 0;

  // reference model state
  int          m_streak;
  logic [1:0]  m_last_g;        // {load, fetch} granted in the last cycle
  logic        e_if_v, e_ld_v, e_if_e, e_ld_e;
  logic [31:0] e_if_d, e_ld_d;

  always #5 clk = ~clk;

  // Out-of-range reads return junk so an ignored rom_data is detectable.
  assign rom_data = (rom_address < ROM_BYTES) ? rom[rom_address[11:2]] : 32'hBADC0DE5;

  rom_port_arbiter #(.ROM_BYTES(ROM_BYTES), .MAX_LD_STREAK(MAX_LD)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rerr(if_rerr),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_rerr(ld_rerr),
    .rom_address(rom_address), .rom_data(rom_data)
  );

  function automatic logic [1:0] m_grant();
    if (reset) return 2'b00;
    if (ld_req && (!if_req || m_streak < MAX_LD)) return 2'b10;
    if (if_req) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= ROM_BYTES);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    return m_bad(a) ? 32'h0 : rom[a / 4];
  endfunction

  function automatic logic [31:0] rnd_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
    if (k == 1) return 32'(ROM_BYTES) + {$urandom_range(0, 4000), 2'b00};
    return 32'({$urandom_range(0, 1023), 2'b00});
  endfunction

  // Advance one clock, updating the model from the pre-edge inputs.
  task automatic tick();
    logic [1:0] g = m_grant();
    if (reset) begin
      {e_if_v, e_ld_v, e_if_e, e_ld_e} = '0;
      e_if_d = '0; e_ld_d = '0; m_streak = 0;
    end else begin
      e_if_v = g[0]; e_ld_v = g[1];
      if (g[0]) begin e_if_e = m_bad(if_addr); e_if_d = m_word(if_addr); end
      if (g[1]) begin e_ld_e = m_bad(ld_addr); e_ld_d = m_word(ld_addr); end
      if (!if_req || g[0]) m_streak = 0;
      else if (g[1] && m_streak < MAX_LD) m_streak++;
    end
    m_last_g = g;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic [31:0] la);
    if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 32'h8, 1, 32'h10);
    for (int i = 0; i < 2; i++) begin
      #2;
      vectors++;
      if (if_ready !== 1'b0 || ld_ready !== 1'b0) begin
        errs++; $display("FAIL reset_ready: got if=%b ld=%b, want 0/0", if_ready, ld_ready);
      end
      tick();
    end
    reset = 1'b0;
    #2;
    vectors++;
    if (if_rvalid !== 1'b0 || ld_rvalid !== 1'b0 || if_rdata !== 32'h0 || ld_rerr !== 1'b0) begin
      errs++; $display("FAIL reset_outputs: rvalid if=%b ld=%b if_rdata=%h ld_rerr=%b, want zeros",
                       if_rvalid, ld_rvalid, if_rdata, ld_rerr);
    end
    vectors++;
    if (ld_ready !== 1'b1 || if_ready !== 1'b0) begin
      errs++; $display("FAIL reset_first_grant: got if=%b ld=%b, want load", if_ready, ld_ready);
    end
    tick();
    vectors++;
    if (ld_rvalid !== 1'b1 || ld_rdata !== rom[4] || ld_rerr !== 1'b0) begin
      errs++; $display("FAIL reset_first_resp: got v=%b d=%h e=%b, want 1/%h/0", ld_rvalid, ld_rdata, ld_rerr, rom[4]);
    end
  endtask

  task automatic test_single_fetch();
    drive(1, 32'h20, 0, 32'h0);
    #2;
    vectors++;
    if (if_ready !== 1'b1 || ld_ready !== 1'b0 || rom_address !== 32'h20) begin
      errs++; $display("FAIL fetch_grant: got ready=%b addr=%h, want 1/00000020", if_ready, rom_address);
    end
    tick();
    drive(0, 32'h0, 0, 32'h0);
    vectors++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || if_rerr !== 1'b0 || ld_rvalid !== 1'b0) begin
      errs++; $display("FAIL fetch_resp: got v=%b d=%h e=%b, want 1/deadbeef/0", if_rvalid, if_rdata, if_rerr);
    end
    tick();
  endtask

  task automatic test_contention();
    bit pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    drive(0, 0, 0, 0);
    tick();
    drive(1, rnd_addr(), 1, rnd_addr());
    for (int c = 0; c < 10; c++) begin
      #2;
      vectors++;
      if (ld_ready !== pat[c] || if_ready !== !pat[c] || rom_address !== (pat[c] ? ld_addr : if_addr)) begin
        errs++; $display("FAIL contention_grant[%0d]: got if=%b ld=%b addr=%h, want ld=%b", c, if_ready, ld_ready, rom_address, pat[c]);
      end
      tick();
      vectors++;
      if (if_rvalid !== e_if_v || ld_rvalid !== e_ld_v || (if_rvalid && ld_rvalid) ||
          (e_if_v && (if_rdata !== e_if_d || if_rerr !== e_if_e)) ||
          (e_ld_v && (ld_rdata !== e_ld_d || ld_rerr !== e_ld_e))) begin
        errs++; $display("FAIL contention_resp[%0d]: got if=%b/%h/%b ld=%b/%h/%b, want if=%b/%h/%b ld=%b/%h/%b", c,
                         if_rvalid, if_rdata, if_rerr, ld_rvalid, ld_rdata, ld_rerr,
                         e_if_v, e_if_d, e_if_e, e_ld_v, e_ld_d, e_ld_e);
      end
      if (m_last_g[0]) if_addr = rnd_addr();
      if (m_last_g[1]) ld_addr = rnd_addr();
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3] = '{32'h102, 32'h1000, 32'hFFC};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, addrs[i]);
      tick();
      drive(0, 0, 0, 0);
      vectors++;
      if (ld_rvalid !== 1'b1 || ld_rerr !== (i != 2) || ld_rdata !== (i == 2 ? rom[1023] : 32'h0)) begin
        errs++; $display("FAIL error_%h: got v=%b e=%b d=%h", addrs[i], ld_rvalid, ld_rerr, ld_rdata);
      end
    end
    // data and error flag hold while idle
    tick();
    vectors++;
    if (ld_rvalid !== 1'b0 || ld_rdata !== rom[1023] || ld_rerr !== 1'b0) begin
      errs++; $display("FAIL error_hold: got v=%b d=%h e=%b, want 0/%h/0", ld_rvalid, ld_rdata, ld_rerr, rom[1023]);
    end
    drive(1, 32'h5, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    vectors++;
    if (if_rvalid !== 1'b1 || if_rerr !== 1'b1 || if_rdata !== 32'h0) begin
      errs++; $display("FAIL error_fetch_misaligned: got v=%b e=%b d=%h, want 1/1/0", if_rvalid, if_rerr, if_rdata);
    end
    tick();
  endtask

  // Expect n load grants in a row with both requesting, then a fetch grant.
  task automatic test_streak_clear();
    drive(0, 0, 0, 0);
    tick();
    drive(1, 32'h40, 1, 32'h80);
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++;
      if (ld_ready !== 1'b1) begin
        errs++; $display("FAIL streak_pre[%0d]: got ld_ready=%b, want 1", i, ld_ready);
      end
      tick();
    end
    if_req = 1'b0;
    tick();
    if_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      vectors++;
      if (ld_ready !== (i < 4) || if_ready !== (i == 4)) begin
        errs++; $display("FAIL streak_clear[%0d]: got if=%b ld=%b, want ld=%b", i, if_ready, ld_ready, i < 4);
      end
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h44, 1, 32'h88);
    tick(); tick();
    reset = 1'b1;
    #2;
    vectors++;
    if (ld_ready !== 1'b0 || if_ready !== 1'b0) begin
      errs++; $display("FAIL reset_mid_ready: got if=%b ld=%b, want 0/0", if_ready, ld_ready);
    end
    tick();
    reset = 1'b0;
    vectors++;
    if (ld_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
      errs++; $display("FAIL reset_mid_rvalid: got if=%b ld=%b, want 0/0", if_rvalid, ld_rvalid);
    end
    // streak cleared: four loads before fetch again
    for (int i = 0; i < 5; i++) begin
      #2;
      vectors++;
      if (ld_ready !== (i < 4) || if_ready !== (i == 4)) begin
        errs++; $display("FAIL reset_mid_streak[%0d]: got if=%b ld=%b, want ld=%b", i, if_ready, ld_ready, i < 4);
      end
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    for (int c = 0; c < 300; c++) begin
      // pending requests stay stable until granted
      if (!(if_req && !m_last_g[0])) begin if_req = 1'($urandom_range(0, 1)); if_addr = rnd_addr(); end
      if (!(ld_req && !m_last_g[1])) begin ld_req = 1'($urandom_range(0, 2) != 0); ld_addr = rnd_addr(); end
      #2;
      g = m_grant();
      vectors++;
      if ({ld_ready, if_ready} !== g || rom_address !== (g[1] ? ld_addr : g[0] ? if_addr : 32'h0)) begin
        errs++; $display("FAIL rand_grant[%0d]: got ld/if=%b%b addr=%h, want %b", c, ld_ready, if_ready, rom_address, g);
      end
      tick();
      vectors++;
      if (if_rvalid !== e_if_v || ld_rvalid !== e_ld_v || (if_rvalid && ld_rvalid) ||
          if_rdata !== e_if_d || if_rerr !== e_if_e || ld_rdata !== e_ld_d || ld_rerr !== e_ld_e) begin
        errs++; $display("FAIL rand_resp[%0d]: got if=%b/%h/%b ld=%b/%h/%b, want if=%b/%h/%b ld=%b/%h/%b", c,
                         if_rvalid, if_rdata, if_rerr, ld_rvalid, ld_rdata, ld_rerr,
                         e_if_v, e_if_d, e_if_e, e_ld_v, e_ld_d, e_ld_e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[8] = 32'hDEADBEEF;
    m_streak = 0; m_last_g = 2'b00;
    {e_if_v, e_ld_v, e_if_e, e_ld_e} = '0;
    e_if_d = '0; e_ld_d = '0;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    test_reset();
    test_single_fetch();
    test_contention();
    test_errors();
    test_streak_clear();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
